// File: rtl/spi_fb_pkg.sv
// spi_fb_pkg: shared types and constants for the SPI framebuffer slave.
//   spi_fb_state_t : protocol FSM states
//   CMD_*          : command byte values recognised in the first byte of a frame
package spi_fb_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddrHi,
      StAddrLo,
      StData,
      StStatus,
      StIgnore
   } spi_fb_state_t;

   localparam logic [7:0] CMD_WRITE  = 8'h01;
   localparam logic [7:0] CMD_STATUS = 8'h02;
   localparam logic [7:0] CMD_SWAP   = 8'h03;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer for one asynchronous input plus
// rise/fall detection on the synchronized value.
//   clk, reset : system clock, synchronous active-high reset
//   din        : asynchronous input
//   sync       : synchronized level
//   rise, fall : one-cycle pulses on synchronized edges
module spi_sync_edge #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain_q;
   logic              prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         chain_q <= {STAGES{RESET_VAL}};
         prev_q  <= RESET_VAL;
      end else begin
         chain_q <= {chain_q[STAGES-2:0], din};
         prev_q  <= chain_q[STAGES-1];
      end
   end

   assign sync = chain_q[STAGES-1];
   assign rise = sync & ~prev_q;
   assign fall = ~sync & prev_q;

endmodule

// File: rtl/spi_fb_slave.sv
// spi_fb_slave: SPI mode-0 slave that parses framed commands and writes packed
// pixel words into the framebuffer write port.
//   clk, reset                 : system clock, synchronous active-high reset
//   spi_sclk/mosi/ss_n         : asynchronous SPI inputs
//   spi_miso, spi_miso_oe      : SPI data out and its tristate enable
//   fb_we, fb_addr, fb_wdata   : framebuffer write port (one-cycle strobe)
//   status_in                  : byte returned by the STATUS command
//   swap_req                   : one-cycle buffer swap request
//   err_cnt                    : saturating count of unknown commands
module spi_fb_slave
   import spi_fb_pkg::*;
#(
   parameter int unsigned PIXEL_BYTES = 3,
   parameter int unsigned ADDR_W      = 11,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     spi_sclk,
   input  logic                     spi_mosi,
   input  logic                     spi_ss_n,
   output logic                     spi_miso,
   output logic                     spi_miso_oe,
   output logic                     fb_we,
   output logic [ADDR_W-1:0]        fb_addr,
   output logic [8*PIXEL_BYTES-1:0] fb_wdata,
   input  logic [7:0]               status_in,
   output logic                     swap_req,
   output logic [7:0]               err_cnt
);

   localparam int unsigned PW = 8 * PIXEL_BYTES;

   logic sclk_sync_unused, sclk_rise, sclk_fall;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;
   logic ss_s, ss_rise, ss_fall;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk   (clk),
      .reset (reset),
      .din   (spi_sclk),
      .sync  (sclk_sync_unused),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk   (clk),
      .reset (reset),
      .din   (spi_mosi),
      .sync  (mosi_s),
      .rise  (mosi_rise_unused),
      .fall  (mosi_fall_unused)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
      .clk   (clk),
      .reset (reset),
      .din   (spi_ss_n),
      .sync  (ss_s),
      .rise  (ss_rise),
      .fall  (ss_fall)
   );

   spi_fb_state_t     state_q, state_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shreg_q, shreg_d;
   logic [7:0]        addr_hi_q, addr_hi_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [PW-1:0]     pix_q, pix_d;
   logic [1:0]        pix_cnt_q, pix_cnt_d;
   logic [7:0]        miso_q, miso_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic [PW-1:0]     fb_wdata_q, fb_wdata_d;
   logic              swap_q, swap_d;
   logic [7:0]        err_q, err_d;

   logic [7:0]  rx_byte;
   logic        byte_done;
   logic [PW-1:0] word;
   logic [15:0] full_addr;

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      addr_hi_d  = addr_hi_q;
      addr_d     = addr_q;
      pix_d      = pix_q;
      pix_cnt_d  = pix_cnt_q;
      miso_d     = miso_q;
      we_d       = 1'b0;
      fb_addr_d  = fb_addr_q;
      fb_wdata_d = fb_wdata_q;
      swap_d     = 1'b0;
      err_d      = err_q;

      rx_byte   = {shreg_q[6:0], mosi_s};
      byte_done = (state_q != StIdle) && sclk_rise && (bit_cnt_q == 3'd7);
      word      = pix_q << 8;
      word[7:0] = rx_byte;
      full_addr = {addr_hi_q, rx_byte};

      // Deselect beats everything, including a byte completing this cycle.
      if (ss_rise) begin
         state_d = StIdle;
      end else if (state_q == StIdle) begin
         if (ss_fall) begin
            state_d   = StCmd;
            bit_cnt_d = 3'd0;
            shreg_d   = 8'h00;
            pix_cnt_d = 2'd0;
         end
      end else begin
         if (sclk_rise) begin
            shreg_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
         end
         // The falling edge that follows a byte boundary must not shift, so the
         // MSB loaded at the boundary is still on MISO at the next rising edge.
         if (sclk_fall && (state_q == StStatus) && (bit_cnt_q != 3'd0)) begin
            miso_d = {miso_q[6:0], 1'b0};
         end
         if (byte_done) begin
            case (state_q)
               StCmd: begin
                  if (rx_byte == CMD_WRITE) begin
                     state_d = StAddrHi;
                  end else if (rx_byte == CMD_STATUS) begin
                     state_d = StStatus;
                     miso_d  = status_in;
                  end else if (rx_byte == CMD_SWAP) begin
                     state_d = StIgnore;
                     swap_d  = 1'b1;
                  end else begin
                     state_d = StIgnore;
                     if (err_q != 8'hFF) err_d = err_q + 8'd1;
                  end
               end
               StAddrHi: begin
                  addr_hi_d = rx_byte;
                  state_d   = StAddrLo;
               end
               StAddrLo: begin
                  addr_d  = full_addr[ADDR_W-1:0];
                  state_d = StData;
               end
               StData: begin
                  pix_d = word;
                  if (pix_cnt_q == 2'(PIXEL_BYTES - 1)) begin
                     we_d       = 1'b1;
                     fb_addr_d  = addr_q;
                     fb_wdata_d = word;
                     addr_d     = addr_q + ADDR_W'(1);
                     pix_cnt_d  = 2'd0;
                  end else begin
                     pix_cnt_d = pix_cnt_q + 2'd1;
                  end
               end
               StStatus: miso_d = 8'h00;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         bit_cnt_q  <= 3'd0;
         shreg_q    <= 8'h00;
         addr_hi_q  <= 8'h00;
         addr_q     <= '0;
         pix_q      <= '0;
         pix_cnt_q  <= 2'd0;
         miso_q     <= 8'h00;
         we_q       <= 1'b0;
         fb_addr_q  <= '0;
         fb_wdata_q <= '0;
         swap_q     <= 1'b0;
         err_q      <= 8'h00;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
         addr_hi_q  <= addr_hi_d;
         addr_q     <= addr_d;
         pix_q      <= pix_d;
         pix_cnt_q  <= pix_cnt_d;
         miso_q     <= miso_d;
         we_q       <= we_d;
         fb_addr_q  <= fb_addr_d;
         fb_wdata_q <= fb_wdata_d;
         swap_q     <= swap_d;
         err_q      <= err_d;
      end
   end

   assign spi_miso    = (state_q == StStatus) & miso_q[7];
   assign spi_miso_oe = ~ss_s;
   assign fb_we       = we_q;
   assign fb_addr     = fb_addr_q;
   assign fb_wdata    = fb_wdata_q;
   assign swap_req    = swap_q;
   assign err_cnt     = err_q;

endmodule
